port_packet_reader: RTL and testbench
=====================================

# port_packet_reader

Per-output-port read-out stage, directly downstream of each SRAM's `sram_interface`. It takes a dequeued packet head address, walks the packet page by page through the SRAM read port and the jump-table `rd_next_page` link, and strips 8-word pages down to the true packet length. It streams the words to the output port through a 16-entry FIFO with ready/valid backpressure, and returns every fully read page to the owning SRAM's free list.

## Interface
- No parameters. Page = 8 words × 16 bit; address = {sram_idx[4:0], page[10:0]}.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_vld`  in  1  dequeue request for one packet.
- `req_head_addr`  in  16  packet head address {sram_idx, page}.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_vld && req_ready`.
- `rd_page_vld`  out  1  one-cycle page read command.
- `rd_sram_sel`  out  5  target SRAM index (= cur_addr[15:11]).
- `rd_page`  out  11  target page (= cur_addr[10:0]).
- `rd_xfer_data_vld`  in  1  read beat valid from the selected SRAM.
- `rd_xfer_data`  in  16  read beat data.
- `rd_next_page`  in  16  jump-table successor; valid together with beat 0 of each page.
- `out_data_vld`  out  1  FIFO non-empty.
- `out_data`  out  16  FIFO head word.
- `out_end_of_packet`  out  1  FIFO head is the packet's last word.
- `out_ready`  in  1  port consumes the head word when `out_data_vld && out_ready`.
- `page_release_vld`  out  1  one-cycle pulse: page fully read.
- `page_release_addr`  out  16  address of the released page.
- `busy`  out  1  state != IDLE or FIFO non-empty.

## Operation
- States: IDLE, ISSUE, RECV.
- IDLE: on request acceptance latch cur_addr = req_head_addr, set first_page = 1, go to ISSUE.
- ISSUE: `rd_page_vld` = (state == ISSUE) && (FIFO free ≥ 8), combinational. When it is asserted: clear beat counter, go to RECV. Otherwise hold in ISSUE.
- RECV: beat counter (3 bit) advances on each `rd_xfer_data_vld`. Beats need not be contiguous; any read latency ≥ 1 is tolerated.
  - Beat 0: latch next_addr = `rd_next_page`.
  - Beat 0 of the first page: this word is the header; remaining = header[15:7] (9 bit word count including the header). A count of 0 is treated as 1.
  - Push the beat into the FIFO only while remaining > 0, then decrement remaining; the pushed word's eop bit = (remaining == 1).
  - Beats after remaining reaches 0 are discarded. The page always returns 8 beats.
  - Beat 7: pulse release of cur_addr on the next cycle and clear first_page. If remaining == 0 (after this beat's update), go to IDLE; else cur_addr = next_addr and go to ISSUE.
- FIFO: 16 × 17 bit (data + eop), with count 0..16.
  - Push and pop may occur in the same cycle.
  - It never overflows, because 8 slots are reserved before every issue.
  - A pop while empty is ignored.
- `rd_xfer_data_vld` outside RECV is ignored.
- `rd_next_page` on the last page is ignored.
- Reset mid-packet: the FSM goes to IDLE and the FIFO empties. The in-flight page is not released; reclaiming it is the system's responsibility.

## Timing
- Reset values:
  - `rd_page_vld` = 0, `out_data_vld` = 0, `out_end_of_packet` = 0, `page_release_vld` = 0, `page_release_addr` = 0, `busy` = 0.
  - `req_ready` = 1 from the first cycle after `rst` deasserts.
- Request accepted in cycle T → `rd_page_vld` in T+1 (FIFO empty).
- Beat pushed in cycle B → `out_data_vld` in B+1.
- Beat 7 in cycle P → `page_release_vld` in P+1.
- Continuing packet: next `rd_page_vld` in P+1, if FIFO free ≥ 8.
- Finished packet: `req_ready` high in P+1. A new request is accepted in P+1 while older words are still draining; `busy` stays high during the drain.
- Arithmetic:
  - Page count = ceil(len/8).
  - remaining is 9 bit and never goes below 0.
  - The counter and FIFO pointers wrap naturally at 8 and 16.

## Test plan
- Single page: head 0x0805, header 0x0283 (len 5), beats 1 cycle after issue, `out_ready` = 1 → exactly 5 words out, eop on word 5. Beats 5–7 dropped. Release 0x0805 one cycle after beat 7. `req_ready` high again.
- Multi-page chain: len 20; `rd_next_page` 0x0805→0x0812→0x0833 → `rd_page` sequence 0x005, 0x012, 0x033, all with `rd_sram_sel` = 1. Output 20 words, eop on word 20. Three releases in order.
- Backpressure: len 24, `out_ready` = 0 → FIFO fills to 16 after 2 pages and the third issue stalls. Raising `out_ready` at 8 or more free slots triggers the third `rd_page_vld`. No word is lost or duplicated.
- Exact page boundary: len 16 → two pages, eop on beat 7 of page 2, no third issue.
- Header length 0 → one word out carrying eop, one page released.
- Reset asserted during RECV beat 3 → the next cycle shows all outputs at reset values, no release pulse, and `req_ready` = 1.

Source files
------------

// File: rtl/port_packet_reader_if.sv
// Handshake bundle between a packet reader, its SRAM read port, the output port and the free list.
// The master modport is the reader's view; slave is the surrounding system's view.
interface port_packet_reader_if;
    logic        req_vld;
    logic [15:0] req_head_addr;
    logic        req_ready;
    logic        rd_page_vld;
    logic [4:0]  rd_sram_sel;
    logic [10:0] rd_page;
    logic        rd_xfer_data_vld;
    logic [15:0] rd_xfer_data;
    logic [15:0] rd_next_page;
    logic        out_data_vld;
    logic [15:0] out_data;
    logic        out_end_of_packet;
    logic        out_ready;
    logic        page_release_vld;
    logic [15:0] page_release_addr;
    logic        busy;

    modport master (
        input  req_vld, req_head_addr, rd_xfer_data_vld, rd_xfer_data, rd_next_page, out_ready,
        output req_ready, rd_page_vld, rd_sram_sel, rd_page, out_data_vld, out_data,
        output out_end_of_packet, page_release_vld, page_release_addr, busy
    );

    modport slave (
        output req_vld, req_head_addr, rd_xfer_data_vld, rd_xfer_data, rd_next_page, out_ready,
        input  req_ready, rd_page_vld, rd_sram_sel, rd_page, out_data_vld, out_data,
        input  out_end_of_packet, page_release_vld, page_release_addr, busy
    );
endinterface

// File: rtl/port_packet_reader.sv
// Walks a packet's page chain through the SRAM read port, trims it to the header length,
// streams the words through a 16-entry FIFO and releases each page once fully read.
module port_packet_reader (
    input logic                  clk,
    input logic                  rst,
    port_packet_reader_if.master bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StRecv} state_e;

    state_e      state_q, state_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [15:0] next_addr_q, next_addr_d;
    logic        first_page_q, first_page_d;
    logic [2:0]  beat_q, beat_d;
    logic [8:0]  remaining_q, remaining_d;
    logic        rel_vld_q, rel_vld_d;
    logic [15:0] rel_addr_q, rel_addr_d;

    logic [16:0] fifo_mem [16];
    logic [3:0]  wr_ptr_q, rd_ptr_q;
    logic [4:0]  count_q;
    logic        push, pop;
    logic [16:0] push_word;
    logic [8:0]  hdr_len, rem_cur;

    assign bus.req_ready   = (state_q == StIdle);
    // Issue only when a whole page fits, so the FIFO can never overflow.
    assign bus.rd_page_vld = (state_q == StIssue) && (count_q <= 5'd8);
    assign bus.rd_sram_sel = cur_addr_q[15:11];
    assign bus.rd_page     = cur_addr_q[10:0];

    assign pop                   = (count_q != 5'd0) && bus.out_ready;
    assign bus.out_data_vld      = (count_q != 5'd0);
    assign bus.out_data          = fifo_mem[rd_ptr_q][15:0];
    assign bus.out_end_of_packet = (count_q != 5'd0) && fifo_mem[rd_ptr_q][16];
    assign bus.page_release_vld  = rel_vld_q;
    assign bus.page_release_addr = rel_addr_q;
    assign bus.busy              = (state_q != StIdle) || (count_q != 5'd0);

    assign hdr_len = bus.rd_xfer_data[15:7];

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        next_addr_d  = next_addr_q;
        first_page_d = first_page_q;
        beat_d       = beat_q;
        remaining_d  = remaining_q;
        rel_vld_d    = 1'b0;
        rel_addr_d   = rel_addr_q;
        push         = 1'b0;
        push_word    = {1'b0, bus.rd_xfer_data};
        rem_cur      = remaining_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_vld) begin
                    cur_addr_d   = bus.req_head_addr;
                    first_page_d = 1'b1;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (bus.rd_page_vld) begin
                    beat_d  = 3'd0;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (bus.rd_xfer_data_vld) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd0) begin
                        next_addr_d = bus.rd_next_page;
                        // Header word carries the total word count; zero means a lone header.
                        if (first_page_q) begin
                            rem_cur = (hdr_len == 9'd0) ? 9'd1 : hdr_len;
                        end
                    end
                    if (rem_cur != 9'd0) begin
                        push        = 1'b1;
                        push_word   = {rem_cur == 9'd1, bus.rd_xfer_data};
                        remaining_d = rem_cur - 9'd1;
                    end else begin
                        remaining_d = rem_cur;
                    end
                    if (beat_q == 3'd7) begin
                        rel_vld_d    = 1'b1;
                        rel_addr_d   = cur_addr_q;
                        first_page_d = 1'b0;
                        if (remaining_d == 9'd0) begin
                            state_d = StIdle;
                        end else begin
                            cur_addr_d = next_addr_q;
                            state_d    = StIssue;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_addr_q   <= 16'd0;
            next_addr_q  <= 16'd0;
            first_page_q <= 1'b0;
            beat_q       <= 3'd0;
            remaining_q  <= 9'd0;
            rel_vld_q    <= 1'b0;
            rel_addr_q   <= 16'd0;
            wr_ptr_q     <= 4'd0;
            rd_ptr_q     <= 4'd0;
            count_q      <= 5'd0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            next_addr_q  <= next_addr_d;
            first_page_q <= first_page_d;
            beat_q       <= beat_d;
            remaining_q  <= remaining_d;
            rel_vld_q    <= rel_vld_d;
            rel_addr_q   <= rel_addr_d;
            if (push) wr_ptr_q <= wr_ptr_q + 4'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 4'd1;
            count_q <= count_q + {4'd0, push} - {4'd0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) fifo_mem[wr_ptr_q] <= push_word;
    end
endmodule

// File: tb/tb_port_packet_reader.sv
// Directed bench: an SRAM responder model feeds page beats, a monitor collects outputs,
// and a vector table drives whole-packet reads plus a mid-packet reset sequence.
module tb_port_packet_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    port_packet_reader_if bus ();

    port_packet_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] hdr;
        logic [15:0] c0, c1, c2;
        int          mode;       // 0 always ready, 1 toggling ready, 2 held-off then ready
        int          lat;
        bit          gap;
        int          exp_words;
        int          exp_pages;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder state
    logic [15:0] chain [4];
    logic [15:0] resp_hdr;
    bit          resp_first;
    int          resp_lat = 1;
    bit          gap_mode;
    int          pg_idx;
    int          beat_drv;
    logic [15:0] pend_q [$];
    bit          r_active;
    bit          r_gapped;
    int          r_beat;
    int          r_wait;
    logic [15:0] r_pg;

    // monitor queues
    int          b7_q [$];
    logic [16:0] rx_q [$];
    logic [15:0] iss_q [$];
    int          iss_rx [$];
    logic [15:0] rel_q [$];
    int          rel_cyc [$];

    vec_t vecs [6];

    function automatic logic [15:0] page_word(logic [15:0] a, int b);
        return {a[7:0], 5'b10100, 3'(b)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // SRAM read-port model: latency resp_lat after an issue, optional bubbles before beats 3 and 6
    initial begin
        bus.rd_xfer_data_vld = 1'b0;
        bus.rd_xfer_data     = 16'd0;
        bus.rd_next_page     = 16'd0;
        beat_drv = -1;
        r_active = 1'b0;
        r_gapped = 1'b0;
        forever begin
            @(negedge clk);
            bus.rd_xfer_data_vld = 1'b0;
            bus.rd_next_page     = 16'hdead;
            beat_drv = -1;
            if (rst) begin
                pend_q.delete();
                r_active = 1'b0;
                continue;
            end
            if (!r_active && pend_q.size() > 0) begin
                if (r_wait > 1) r_wait--;
                else begin
                    r_pg     = pend_q.pop_front();
                    r_beat   = 0;
                    r_active = 1'b1;
                end
            end
            if (r_active) begin
                if (gap_mode && (r_beat == 3 || r_beat == 6) && !r_gapped) begin
                    r_gapped = 1'b1;
                end else begin
                    r_gapped = 1'b0;
                    bus.rd_xfer_data_vld = 1'b1;
                    bus.rd_xfer_data = (r_beat == 0 && resp_first) ? resp_hdr : page_word(r_pg, r_beat);
                    if (r_beat == 0) bus.rd_next_page = (pg_idx < 3) ? chain[pg_idx + 1] : 16'hffff;
                    beat_drv = r_beat;
                    if (r_beat == 7) begin
                        b7_q.push_back(cyc);
                        r_active   = 1'b0;
                        resp_first = 1'b0;
                        pg_idx++;
                    end
                    r_beat++;
                end
            end
            if (bus.rd_page_vld) begin
                pend_q.push_back({bus.rd_sram_sel, bus.rd_page});
                r_wait = resp_lat;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.rd_page_vld) begin
                iss_q.push_back({bus.rd_sram_sel, bus.rd_page});
                iss_rx.push_back(rx_q.size());
            end
            if (!rst && bus.out_data_vld && bus.out_ready)
                rx_q.push_back({bus.out_end_of_packet, bus.out_data});
            if (bus.page_release_vld) begin
                rel_q.push_back(bus.page_release_addr);
                rel_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_queues();
        b7_q.delete();
        rx_q.delete();
        iss_q.delete();
        iss_rx.delete();
        rel_q.delete();
        rel_cyc.delete();
    endtask

    task automatic start_packet(vec_t v);
        int t;
        t = 0;
        while ((bus.busy || !bus.req_ready) && t < 200) begin
            tick();
            t++;
        end
        check("idle_before_req", {31'd0, bus.req_ready}, 32'd1);
        chain[0] = v.c0; chain[1] = v.c1; chain[2] = v.c2; chain[3] = 16'hffff;
        resp_hdr = v.hdr; resp_first = 1'b1; pg_idx = 0;
        resp_lat = v.lat; gap_mode = v.gap;
        clear_queues();
        bus.out_ready     = (v.mode != 2);
        bus.req_vld       = 1'b1;
        bus.req_head_addr = v.c0;
        tick();
        bus.req_vld = 1'b0;
        check("issue_latency", {31'd0, bus.rd_page_vld}, 32'd1);
        check("issue_addr", {16'd0, bus.rd_sram_sel, bus.rd_page}, {16'd0, v.c0});
        check("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
    endtask

    task automatic run_vec(vec_t v, int id);
        int          t;
        bit          bp_done;
        logic [15:0] cv [3];
        logic [16:0] exp_w;
        cv[0] = v.c0; cv[1] = v.c1; cv[2] = v.c2;
        start_packet(v);
        t = 0;
        bp_done = 1'b0;
        while (!(rx_q.size() >= v.exp_words && rel_q.size() >= v.exp_pages && !bus.busy)
               && t < 800) begin
            if (v.mode == 1) bus.out_ready = ~bus.out_ready;
            if (v.mode == 2 && !bp_done && rel_q.size() >= 2) begin
                repeat (4) tick();
                t += 4;
                check("bp_stall_issues", iss_q.size(), 2);
                check("bp_head_vld", {31'd0, bus.out_data_vld}, 32'd1);
                check("bp_no_pop", rx_q.size(), 0);
                bus.out_ready = 1'b1;
                bp_done = 1'b1;
            end
            tick();
            t++;
        end
        if (t >= 800) begin
            checks++;
            errors++;
            $display("FAIL vec%0d_timeout: got %0d words %0d releases, required %0d and %0d",
                     id, rx_q.size(), rel_q.size(), v.exp_words, v.exp_pages);
        end
        repeat (12) tick();
        check($sformatf("vec%0d_word_count", id), rx_q.size(), v.exp_words);
        check($sformatf("vec%0d_issue_count", id), iss_q.size(), v.exp_pages);
        check($sformatf("vec%0d_release_count", id), rel_q.size(), v.exp_pages);
        for (int k = 0; k < v.exp_words && k < rx_q.size(); k++) begin
            exp_w = {k == v.exp_words - 1, (k == 0) ? v.hdr : page_word(cv[k / 8], k % 8)};
            check($sformatf("vec%0d_word%0d", id, k), rx_q[k], exp_w);
        end
        for (int p = 0; p < v.exp_pages; p++) begin
            if (p < iss_q.size()) check($sformatf("vec%0d_issue%0d", id, p), iss_q[p], cv[p]);
            if (p < rel_q.size()) check($sformatf("vec%0d_rel%0d", id, p), rel_q[p], cv[p]);
            if (p < rel_cyc.size() && p < b7_q.size())
                check($sformatf("vec%0d_rel_timing%0d", id, p), rel_cyc[p], b7_q[p] + 1);
        end
        if (v.mode == 2 && iss_rx.size() > 2) check("bp_third_issue_pops", iss_rx[2], 8);
        check($sformatf("vec%0d_busy_end", id), {31'd0, bus.busy}, 32'd0);
        check($sformatf("vec%0d_ready_end", id), {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int t;
        vecs[0] = '{16'h0283, 16'h0805, 16'hbeef, 16'hbeef, 0, 1, 1'b0, 5, 1};
        vecs[1] = '{16'h0a03, 16'h0805, 16'h0812, 16'h0833, 1, 1, 1'b0, 20, 3};
        vecs[2] = '{16'h0803, 16'h1001, 16'h1002, 16'hbeef, 0, 2, 1'b0, 16, 2};
        vecs[3] = '{16'h0003, 16'h0400, 16'hbeef, 16'hbeef, 0, 1, 1'b0, 1, 1};
        vecs[4] = '{16'h0c03, 16'h0805, 16'h0812, 16'h0833, 2, 1, 1'b0, 24, 3};
        vecs[5] = '{16'h0483, 16'h2003, 16'h2004, 16'hbeef, 0, 3, 1'b1, 9, 2};

        bus.req_vld       = 1'b0;
        bus.req_head_addr = 16'd0;
        bus.out_ready     = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_rd_page_vld", {31'd0, bus.rd_page_vld}, 32'd0);
        check("rst_out_vld", {31'd0, bus.out_data_vld}, 32'd0);
        rst = 1'b0;
        tick();
        check("init_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("init_busy", {31'd0, bus.busy}, 32'd0);
        check("init_eop", {31'd0, bus.out_end_of_packet}, 32'd0);
        check("init_rel_vld", {31'd0, bus.page_release_vld}, 32'd0);
        check("init_rel_addr", {16'd0, bus.page_release_addr}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset while the responder is presenting beat 3 of the first page
        start_packet(vecs[1]);
        bus.out_ready = 1'b0;
        t = 0;
        while (beat_drv != 3 && t < 50) begin
            tick();
            t++;
        end
        check("pre_rst_beat3", beat_drv, 3);
        check("pre_rst_out_vld", {31'd0, bus.out_data_vld}, 32'd1);
        clear_queues();
        rst = 1'b1;
        tick();
        check("mid_rst_rd_page_vld", {31'd0, bus.rd_page_vld}, 32'd0);
        check("mid_rst_out_vld", {31'd0, bus.out_data_vld}, 32'd0);
        check("mid_rst_eop", {31'd0, bus.out_end_of_packet}, 32'd0);
        check("mid_rst_rel_vld", {31'd0, bus.page_release_vld}, 32'd0);
        check("mid_rst_rel_addr", {16'd0, bus.page_release_addr}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (15) tick();
        check("post_rst_no_release", rel_q.size(), 0);
        check("post_rst_no_issue", iss_q.size(), 0);
        check("post_rst_idle", {31'd0, bus.busy}, 32'd0);

        run_vec(vecs[0], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
